// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU control encodings and slot FSM states.
package alu_share_arbiter_pkg;

    localparam int unsigned AluCtrlW = 4;

    // RV32I ALUControl encodings understood by the shared ALU
    typedef enum logic [AluCtrlW-1:0] {
        AluAdd  = 4'b0000,
        AluSub  = 4'b1000,
        AluSll  = 4'b0001,
        AluSlt  = 4'b0010,
        AluSltu = 4'b0011,
        AluXor  = 4'b0100,
        AluSrl  = 4'b0101,
        AluSra  = 4'b1101,
        AluOr   = 4'b0110,
        AluAnd  = 4'b0111
    } alu_ctrl_e;

    // Single-entry response slot
    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after the last grant and wraps.
module alu_share_arbiter_rr_arbiter #(
    parameter int unsigned N    = 2,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [N-1:0]    grant_o
);

    // Two ascending passes: indices above last_i win first, then the wrapped range
    always_comb begin
        logic found;
        grant_o = '0;
        found   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (IdxW'(j) > last_i)) begin
                grant_o[j] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (IdxW'(j) <= last_i)) begin
                grant_o[j] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters; round-robin grant, and the
// result is captured in a single-entry response slot with 1-cycle latency.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CTRL_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_srca,
    input  logic [NUM_REQ*WIDTH-1:0]   req_srcb,
    input  logic [NUM_REQ*CTRL_W-1:0]  req_ctrl,
    output logic [WIDTH-1:0]           alu_srca,
    output logic [WIDTH-1:0]           alu_srcb,
    output logic [CTRL_W-1:0]          alu_ctrl,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_zero,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_zero,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [IdW-1:0]   rsp_id_q, rsp_id_d;
    logic [IdW-1:0]   last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] grant;
    logic [IdW-1:0]     grant_id;
    logic               can_issue;
    logic               accept;

    alu_share_arbiter_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .last_i  (last_grant_q),
        .grant_o (grant)
    );

    // Issue gating: slot frees and refills in one cycle; nothing is accepted during reset
    always_comb begin
        can_issue = (state_q == StEmpty) || rsp_ready;
        req_ready = grant & {NUM_REQ{can_issue && !reset}};
        accept    = |(req_valid & req_ready);
    end

    // Operand mux toward the ALU; idle drive is ADD of zeros
    always_comb begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_ctrl = CTRL_W'(AluAdd);
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_srca = req_srca[i*WIDTH +: WIDTH];
                alu_srcb = req_srcb[i*WIDTH +: WIDTH];
                alu_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
                grant_id = IdW'(i);
            end
        end
    end

    // Slot FSM next state and response capture
    always_comb begin
        state_d      = state_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_id_d     = grant_id;
            last_grant_d = grant_id;
        end
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (rsp_ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // State registers; last grant resets to the top index so requester 0 goes first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StEmpty;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= '0;
            last_grant_q <= IdW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Response outputs straight from the slot registers
    always_comb begin
        rsp_valid  = (state_q == StFull);
        rsp_result = rsp_result_q;
        rsp_zero   = rsp_zero_q;
        rsp_id     = rsp_id_q;
    end

endmodule
